// File: rtl/tx_slot_scheduler.sv
// rtl/tx_slot_scheduler.sv - TDMA slot timer with two-way round-robin TX grant
// Optional feature macro: SLOT_GUARD_EN (tx_en masked during slot-end guard ticks).
module tx_slot_scheduler #(
    parameter int SLOT_LEN  = 64,
    parameter int GUARD_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic       ce_25m,
    output logic       time_slot_flag,
    output logic [1:0] gnt,
    output logic       tx_en,
    output logic [7:0] slot_cnt,
    output logic       frame_start
);

    localparam int TW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(SLOT_LEN - 1);
    localparam logic [TW-1:0] GUARD_START = TW'(SLOT_LEN - GUARD_LEN);

    generate
        if (SLOT_LEN < 2 || SLOT_LEN > 1024 || GUARD_LEN < 1 || GUARD_LEN >= SLOT_LEN) begin : g_param_check
            $error("tx_slot_scheduler: SLOT_LEN/GUARD_LEN out of range");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [1:0]    phase, phase_nx;
    logic [TW-1:0] tick, tick_nx, tick_inc;
    logic [7:0]    slot_nx;
    logic [1:0]    gnt_nx, arb;
    logic          last_hi, last_hi_nx;
    logic          flag_nx, fs_nx, ce_nx, tx_nx, new_slot, wrap;

    // last_hi=1 means req[1] won the last non-empty grant, so req[0] goes first on a tie
    always_comb begin
        case (req)
            2'b01:   arb = 2'b01;
            2'b10:   arb = 2'b10;
            2'b11:   arb = last_hi ? 2'b01 : 2'b10;
            default: arb = 2'b00;
        endcase
    end

    assign wrap     = (phase == 2'd3) && (tick == TICK_LAST);
    assign tick_inc = (phase == 2'd3) ? (wrap ? '0 : tick + TW'(1)) : tick;

    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        tick_nx    = tick;
        slot_nx    = slot_cnt;
        gnt_nx     = gnt;
        last_hi_nx = last_hi;
        new_slot   = 1'b0;
        case (state)
            IDLE: begin
                phase_nx = 2'd0;
                tick_nx  = '0;
                gnt_nx   = 2'b00;
                if (en) begin
                    state_nx = RUN;
                    new_slot = 1'b1;
                    slot_nx  = 8'd0;
                end
            end
            RUN: begin
                phase_nx = phase + 2'd1;
                tick_nx  = tick_inc;
                if (!en) state_nx = DRAIN;
                if (wrap) begin
                    new_slot = 1'b1;
                    slot_nx  = slot_cnt + 8'd1;
                end
            end
            DRAIN: begin
                phase_nx = phase + 2'd1;
                tick_nx  = tick_inc;
                if (wrap) begin
                    if (en) begin
                        state_nx = RUN;
                        new_slot = 1'b1;
                        slot_nx  = slot_cnt + 8'd1;
                    end else begin
                        state_nx = IDLE;
                        phase_nx = 2'd0;
                        tick_nx  = '0;
                        gnt_nx   = 2'b00;
                    end
                end else if (en) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (new_slot) begin
            gnt_nx = arb;
            if (|arb) last_hi_nx = arb[1];
        end
        flag_nx = new_slot;
        fs_nx   = new_slot && (slot_nx == 8'd0);
        ce_nx   = (state_nx != IDLE) && (phase_nx == 2'd3);
`ifdef SLOT_GUARD_EN
        tx_nx   = (|gnt_nx) && (tick_nx < GUARD_START);
`else
        tx_nx   = |gnt_nx;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            phase          <= 2'd0;
            tick           <= '0;
            last_hi        <= 1'b1;
            slot_cnt       <= 8'd0;
            gnt            <= 2'b00;
            tx_en          <= 1'b0;
            ce_25m         <= 1'b0;
            time_slot_flag <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            state          <= state_nx;
            phase          <= phase_nx;
            tick           <= tick_nx;
            last_hi        <= last_hi_nx;
            slot_cnt       <= slot_nx;
            gnt            <= gnt_nx;
            tx_en          <= tx_nx;
            ce_25m         <= ce_nx;
            time_slot_flag <= flag_nx;
            frame_start    <= fs_nx;
        end
    end

endmodule

// File: doc/tx_slot_scheduler.md
TX_SLOT_SCHEDULER -- requirements
Module: tx_slot_scheduler

Interface
REQ-001 SHALL have parameter SLOT_LEN, default 64, slot length in 25 MHz ticks (legal 2..1024).
REQ-002 SHALL have parameter GUARD_LEN, default 4, guard ticks at slot end (legal 1..SLOT_LEN-1).
REQ-003 SHALL have port clk  input  1  100 MHz system clock; sole clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  scheduler enable, level.
REQ-006 SHALL have port req  input  2  per-requester TX slot request, level.
REQ-007 SHALL have port ce_25m  output  1  one-clk strobe every 4 clk (25 MHz enable).
REQ-008 SHALL have port time_slot_flag  output  1  one-clk pulse at each slot start.
REQ-009 SHALL have port gnt  output  2  one-hot slot grant, or 0 when no grant.
REQ-010 SHALL have port tx_en  output  1  granted requester may transmit on ce_25m.
REQ-011 SHALL have port slot_cnt  output  8  index of current slot.
REQ-012 SHALL have port frame_start  output  1  one-clk pulse at start of slot 0.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM SHALL have states IDLE, RUN, DRAIN.
REQ-015 IDLE: phase and tick counters held at 0, ce_25m=0, gnt=0, tx_en=0; en=1 -> RUN next clk.
REQ-016 IDLE->RUN clk SHALL start slot 0: time_slot_flag=1, frame_start=1, slot_cnt=0, gnt from arbitration.
REQ-017 In RUN/DRAIN, 2-bit phase counter SHALL count 0..3 and wrap; ce_25m=1 only in clks where phase==3.
REQ-018 Tick counter SHALL increment on each ce_25m and wrap at SLOT_LEN-1; slot length = 4*SLOT_LEN clk exactly.
REQ-019 On tick wrap in RUN, next clk SHALL have time_slot_flag=1, slot_cnt incremented (255 wraps to 0), gnt re-arbitrated.
REQ-020 frame_start SHALL equal time_slot_flag AND new slot_cnt==0.
REQ-021 Arbitration at slot start: exactly one req bit -> grant it; both -> grant requester not granted in last granted slot; none -> gnt=0.
REQ-022 Round-robin pointer SHALL update only on a non-zero grant; after reset, req[0] has priority.
REQ-023 gnt SHALL be held constant for the whole slot regardless of req changes.
REQ-024 tx_en SHALL equal |gnt, subject to REQ-031.
REQ-025 en=0 sampled in RUN -> DRAIN; current slot completes unchanged.
REQ-026 At DRAIN tick wrap -> IDLE with no time_slot_flag, gnt=0, tx_en=0.
REQ-027 en=1 sampled in DRAIN -> RUN, no slot disruption.
REQ-028 req changes during IDLE SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, all counters 0, pointer to req[0], all outputs 0, including mid-slot.
REQ-030 After rst_n release, first slot start SHALL occur on IDLE->RUN transition per REQ-016.

Configuration
REQ-031 Macro SLOT_GUARD_EN defined: tx_en forced 0 during last GUARD_LEN ticks of each slot (tick >= SLOT_LEN-GUARD_LEN); gnt unchanged.
REQ-032 SLOT_GUARD_EN undefined: no guard; tx_en=|gnt for full slot; GUARD_LEN ignored.

Verification
REQ-033 Defaults, reset, en=1, req=01 -> time_slot_flag pulses every 256 clk; gnt=01 every slot; ce_25m period 4 clk.
REQ-034 req=11 held -> gnt alternates 01,10,01,10 on successive slots.
REQ-035 req=10 at slot start, cleared 10 clk later -> gnt=10 held to slot end; next slot gnt=00, pointer unchanged.
REQ-036 en dropped 20 clk into slot 3 -> gnt held to slot end (236 more clk), then IDLE, no further time_slot_flag.
REQ-037 Run 256 slots -> slot_cnt wraps 255->0 with frame_start=1; rst_n low mid-slot -> all outputs 0 same cycle.
REQ-038 SLOT_GUARD_EN defined, defaults -> tx_en falls 16 clk (4 ticks) before each time_slot_flag; undefined -> tx_en stays 1.
